// File: rtl/clock_set_ctrl.sv
// Front-panel controller for the decade clock/calendar counter: button debounce,
// run/set FSM, 1 Hz advance strobe, field inc/dec commands and digit blink mask.
module clock_set_ctrl #(
  parameter int TICK_DIV  = 50_000_000,
  parameter int DEBOUNCE  = 1_000_000,
  parameter int BLINK_DIV = 12_500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       butt_change,
  input  logic       butt_increase,
  input  logic       butt_decrease,
  input  logic       sw_mode,
  output logic       run_tick,
  output logic [2:0] edit_field,
  output logic       inc_pulse,
  output logic       dec_pulse,
  output logic [7:0] blank_mask
);

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    S_HOUR  = 3'd1,
    S_MIN   = 3'd2,
    S_SEC   = 3'd3,
    S_DAY   = 3'd4,
    S_MONTH = 3'd5,
    S_YEAR  = 3'd6
  } state_e;

  localparam int TW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
  localparam int DW = (DEBOUNCE  > 1) ? $clog2(DEBOUNCE)  : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  // Button index: 0 = change, 1 = increase, 2 = decrease (all active-low).
  logic [2:0]    btn_raw;
  logic [2:0]    btn_s1_q, btn_s2_q, btn_lvl_q, press_q;
  logic [DW-1:0] db_cnt_q [3];

  assign btn_raw = {butt_decrease, butt_increase, butt_change};

  // NOTE: the debounce counters are a handful of flops, not a RAM, so resetting them is cheap and keeps the reset state fully defined.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1_q  <= '1;
      btn_s2_q  <= '1;
      btn_lvl_q <= '1;
      press_q   <= '0;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
    end else begin
      btn_s1_q <= btn_raw;
      btn_s2_q <= btn_s1_q;
      for (int i = 0; i < 3; i++) begin
        press_q[i] <= 1'b0;
        if (btn_s2_q[i] == btn_lvl_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_LAST) begin
          db_cnt_q[i]  <= '0;
          btn_lvl_q[i] <= btn_s2_q[i];
          // Only the released->pressed edge is an event; releases are silent.
          press_q[i]   <= ~btn_s2_q[i];
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DW'(1);
        end
      end
    end
  end

  // Third stage remembers the previous synced mode so a change can be detected.
  logic mode_s1_q, mode_s2_q, mode_s3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_s1_q <= 1'b0;
      mode_s2_q <= 1'b0;
      mode_s3_q <= 1'b0;
    end else begin
      mode_s1_q <= sw_mode;
      mode_s2_q <= mode_s1_q;
      mode_s3_q <= mode_s2_q;
    end
  end

  logic press_chg, press_inc, press_dec, mode_chg;
  assign press_chg = press_q[0];
  assign press_inc = press_q[1];
  assign press_dec = press_q[2];
  assign mode_chg  = mode_s2_q ^ mode_s3_q;

  function automatic logic [7:0] field_mask(input state_e s);
    case (s)
      S_HOUR, S_DAY:  field_mask = 8'hC0;
      S_MIN, S_MONTH: field_mask = 8'h30;
      S_SEC:          field_mask = 8'h0C;
      S_YEAR:         field_mask = 8'h0F;
      default:        field_mask = 8'h00;
    endcase
  endfunction

  state_e        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;
  logic          inc_d, dec_d, run_tick_d;
  logic [7:0]    blank_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    tick_d      = '0;
    blink_cnt_d = '0;
    phase_d     = 1'b0;
    inc_d       = 1'b0;
    dec_d       = 1'b0;

    if (state_q == RUN) begin
      if (press_chg) state_d = mode_s2_q ? S_HOUR : S_DAY;
    end else if (mode_chg) begin
      state_d = RUN;
    end else if (press_chg) begin
      unique case (state_q)
        S_HOUR:  state_d = S_MIN;
        S_MIN:   state_d = S_SEC;
        S_DAY:   state_d = S_MONTH;
        S_MONTH: state_d = S_YEAR;
        default: state_d = RUN;
      endcase
    end else begin
      inc_d = press_inc & ~press_dec;
      dec_d = press_dec & ~press_inc;
    end

    // Outputs are registered from next-state values so they line up with state_q.
    if (state_q == RUN && state_d == RUN)
      tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + TW'(1);
    run_tick_d = (state_d == RUN) && (tick_d == TICK_LAST);

    if (state_d != RUN) begin
      if (state_d != state_q || inc_d || dec_d) begin
        blink_cnt_d = '0;
        phase_d     = 1'b0;
      end else if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
        phase_d     = phase_q;
      end
    end
    blank_d = phase_d ? field_mask(state_d) : 8'h00;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      tick_q      <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      run_tick    <= 1'b0;
      edit_field  <= 3'd0;
      inc_pulse   <= 1'b0;
      dec_pulse   <= 1'b0;
      blank_mask  <= 8'h00;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      run_tick    <= run_tick_d;
      edit_field  <= state_d;
      inc_pulse   <= inc_d;
      dec_pulse   <= dec_d;
      blank_mask  <= blank_d;
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with short dividers (TICK 10, DEBOUNCE 4, BLINK 3).
module tb_clock_set_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       b_chg = 1'b1, b_inc = 1'b1, b_dec = 1'b1, sw = 1'b0;
  logic       run_tick, inc_pulse, dec_pulse;
  logic [2:0] edit_field;
  logic [7:0] blank_mask;

  always #5 clk = ~clk;

  clock_set_ctrl #(.TICK_DIV(10), .DEBOUNCE(4), .BLINK_DIV(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .butt_change  (b_chg),
    .butt_increase(b_inc),
    .butt_decrease(b_dec),
    .sw_mode      (sw),
    .run_tick     (run_tick),
    .edit_field   (edit_field),
    .inc_pulse    (inc_pulse),
    .dec_pulse    (dec_pulse),
    .blank_mask   (blank_mask)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Running totals of output events, sampled on the falling edge.
  int         inc_total = 0, dec_total = 0, tick_in_set = 0;
  logic       inc_prev = 1'b0;
  logic [7:0] blank_after_inc = 8'hFF;

  always @(negedge clk) begin
    if (inc_pulse) inc_total++;
    if (dec_pulse) dec_total++;
    if (run_tick && edit_field != 3'd0) tick_in_set++;
    if (inc_prev) blank_after_inc = blank_mask;
    inc_prev = inc_pulse;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Negedges until run_tick is seen high; -1 if the bound runs out.
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!run_tick && n < 40);
    if (!run_tick) n = -1;
  endtask

  task automatic press(input logic c, input logic i, input logic d, input int hold);
    b_chg = ~c;
    b_inc = ~i;
    b_dec = ~d;
    step(hold);
    b_chg = 1'b1;
    b_inc = 1'b1;
    b_dec = 1'b1;
    step(8);
  endtask

  int n, inc_base, dec_base;

  initial begin
    sw = 1'b1;
    step(3);
    check("rst_run_tick",   32'(run_tick),   0);
    check("rst_edit_field", 32'(edit_field), 0);
    check("rst_inc",        32'(inc_pulse),  0);
    check("rst_dec",        32'(dec_pulse),  0);
    check("rst_blank",      32'(blank_mask), 0);

    // Idle: first tick lands in the 10th RUN cycle, then one every 10 clocks.
    rst_n = 1'b1;
    wait_tick(n);
    check("idle_first_tick", n, 9);
    wait_tick(n);
    check("idle_tick_period1", n, 10);
    wait_tick(n);
    check("idle_tick_period2", n, 10);
    check("idle_edit_field", 32'(edit_field), 0);
    check("idle_blank",      32'(blank_mask), 0);

    // Bouncy change press with sw_mode=1 -> exactly one step into S_HOUR.
    b_chg = 1'b0; step(1);
    b_chg = 1'b1; step(1);
    b_chg = 1'b0; step(8);
    b_chg = 1'b1; step(10);
    check("bounce_one_press", 32'(edit_field), 1);

    // Long increase hold: one pulse, field unchanged, blink restarted visible.
    inc_base = inc_total;
    dec_base = dec_total;
    press(1'b0, 1'b1, 1'b0, 20);
    check("hold_inc_count", inc_total - inc_base, 1);
    check("hold_dec_count", dec_total - dec_base, 0);
    check("hold_edit_field", 32'(edit_field), 1);
    check("blank_after_inc", 32'(blank_after_inc), 0);
    dec_base = dec_total;
    press(1'b0, 1'b0, 1'b1, 8);
    check("hour_dec_count", dec_total - dec_base, 1);

    // Mode change while editing aborts to RUN; inc in RUN is ignored.
    sw = 1'b0;
    step(5);
    check("abort_hour", 32'(edit_field), 0);
    inc_base = inc_total;
    press(1'b0, 1'b1, 0, 8);
    check("run_inc_ignored", inc_total - inc_base, 0);

    // Calendar path and blink pattern in S_DAY.
    press(1'b1, 1'b0, 1'b0, 8);
    check("cal_day", 32'(edit_field), 4);
    n = 0;
    while (blank_mask !== 8'h00 && n < 12) begin step(1); n++; end
    n = 0;
    while (blank_mask !== 8'hC0 && n < 12) begin step(1); n++; end
    check("blink_align", 32'(blank_mask), 'hC0);
    for (int i = 1; i < 12; i++) begin
      step(1);
      check($sformatf("blink_%0d", i), 32'(blank_mask), ((i / 3) % 2 == 0) ? 'hC0 : 'h00);
    end
    press(1'b1, 1'b0, 1'b0, 8);
    check("cal_month", 32'(edit_field), 5);
    press(1'b1, 1'b0, 1'b0, 8);
    check("cal_year", 32'(edit_field), 6);
    press(1'b1, 1'b0, 1'b0, 8);
    check("cal_run", 32'(edit_field), 0);
    check("cal_run_blank", 32'(blank_mask), 0);

    // Abort from S_MIN during a hidden phase; tick restarts from zero.
    sw = 1'b1;
    step(5);
    press(1'b1, 1'b0, 1'b0, 8);
    press(1'b1, 1'b0, 1'b0, 8);
    check("clk_min", 32'(edit_field), 2);
    n = 0;
    while (blank_mask !== 8'h30 && n < 10) begin step(1); n++; end
    check("min_hidden", 32'(blank_mask), 'h30);
    sw = 1'b0;
    n = 0;
    do begin step(1); n++; end while (edit_field != 3'd0 && n < 8);
    check("abort_latency", n, 3);
    check("abort_blank", 32'(blank_mask), 0);
    wait_tick(n);
    check("abort_first_tick", n, 9);

    // Calendar again: change+inc together, then inc+dec together in S_YEAR.
    press(1'b1, 1'b0, 1'b0, 8);
    inc_base = inc_total;
    press(1'b1, 1'b1, 1'b0, 8);
    check("chg_wins_field", 32'(edit_field), 5);
    check("chg_wins_no_inc", inc_total - inc_base, 0);
    press(1'b1, 1'b0, 1'b0, 8);
    inc_base = inc_total;
    dec_base = dec_total;
    press(1'b0, 1'b1, 1'b1, 8);
    check("both_no_inc", inc_total - inc_base, 0);
    check("both_no_dec", dec_total - dec_base, 0);
    check("both_field", 32'(edit_field), 6);
    dec_base = dec_total;
    press(1'b0, 1'b0, 1'b1, 8);
    check("year_dec_count", dec_total - dec_base, 1);

    // Reset mid-edit while digits are blanked.
    n = 0;
    while (blank_mask !== 8'h0F && n < 10) begin step(1); n++; end
    check("year_hidden", 32'(blank_mask), 'h0F);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_edit_field", 32'(edit_field), 0);
    check("midrst_blank",      32'(blank_mask), 0);
    check("midrst_run_tick",   32'(run_tick),   0);
    check("midrst_inc",        32'(inc_pulse),  0);
    check("midrst_dec",        32'(dec_pulse),  0);
    step(2);
    rst_n = 1'b1;
    wait_tick(n);
    check("post_rst_first_tick", n, 9);
    check("post_rst_edit_field", 32'(edit_field), 0);
    check("no_tick_in_set", tick_in_set, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
